// File: rtl/insertion_sort_stream.sv
// Streaming insertion sorter: serial frame in, single-cycle parallel insert, serial sorted frame out.
// Optional argsort output o_index when INSORT_INDEX_EN is defined.
module insertion_sort_stream #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_desc,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_busy
`ifdef INSORT_INDEX_EN
  ,
  output logic [IDX_W-1:0]  o_index
`endif
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   rd_ptr;
  logic               desc;
  logic [DATA_W-1:0]  mem     [DEPTH];
  logic [DATA_W-1:0]  mem_nxt [DEPTH];
  logic [CNT_W-1:0]   pos;
  logic               desc_eff;
  logic               accept;
  logic               out_fire;
  logic               last_out;

  // Direction for the first element of a frame comes straight from the port.
  assign desc_eff = (count == '0) ? i_desc : desc;
  assign accept   = (state == FILL) && i_valid;
  assign last_out = (rd_ptr == count - CNT_W'(1));
  assign out_fire = (state == DRAIN) && i_ready;

  // Counting "<=" (or ">=") entries places equal keys after earlier arrivals.
  always_comb begin
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) begin
        if (desc_eff ? (mem[k] >= i_data) : (mem[k] <= i_data))
          pos = pos + CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      mem_nxt[k] = mem[k];
      if (CNT_W'(k) == pos)
        mem_nxt[k] = i_data;
      else if (CNT_W'(k) > pos && k > 0)
        mem_nxt[k] = mem[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= FILL;
      count  <= '0;
      rd_ptr <= '0;
      desc   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (count == '0) desc <= i_desc;
            for (int k = 0; k < DEPTH; k++) mem[k] <= mem_nxt[k];
            count <= count + CNT_W'(1);
            if (i_last || count == CNT_W'(DEPTH - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (last_out) begin
              count  <= '0;
              rd_ptr <= '0;
              state  <= FILL;
            end else begin
              rd_ptr <= rd_ptr + CNT_W'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef INSORT_INDEX_EN
  logic [IDX_W-1:0] idx     [DEPTH];
  logic [IDX_W-1:0] idx_nxt [DEPTH];

  // Arrival index travels through the same shift network as the data.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      idx_nxt[k] = idx[k];
      if (CNT_W'(k) == pos)
        idx_nxt[k] = count[IDX_W-1:0];
      else if (CNT_W'(k) > pos && k > 0)
        idx_nxt[k] = idx[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) idx[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < DEPTH; k++) idx[k] <= idx_nxt[k];
    end
  end

  assign o_index = (state == DRAIN) ? idx[rd_ptr[IDX_W-1:0]] : '0;
`endif

  assign o_ready = (state == FILL);
  assign o_valid = (state == DRAIN);
  assign o_data  = (state == DRAIN) ? mem[rd_ptr[IDX_W-1:0]] : '0;
  assign o_last  = (state == DRAIN) && last_out;
  assign o_count = count;
  assign o_busy  = (count != '0) || (state == DRAIN);

endmodule

// File: tb/tb_insertion_sort_stream.sv
// Directed bench for insertion_sort_stream with a rank-based reference and an output scoreboard.
// Index checks are active when INSORT_INDEX_EN is defined.
module tb_insertion_sort_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       desc = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ready, out_valid, out_last, busy;
  logic [7:0] out_data;
  logic [3:0] count;
`ifdef INSORT_INDEX_EN
  logic [2:0] index;
`endif

  insertion_sort_stream #(.DATA_W(8), .DEPTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_desc  (desc),
    .i_valid (in_valid),
    .o_ready (ready),
    .i_data  (in_data),
    .i_last  (in_last),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_last  (out_last),
    .o_count (count),
    .o_busy  (busy)
`ifdef INSORT_INDEX_EN
    ,
    .o_index (index)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [2:0] ix;
  } exp_t;

  exp_t exp_q[$];
  int   vals[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream vals in; push the expected sorted frame (stable rank order) when push=1.
  task automatic load(input bit d, input bit use_last, input bit push);
    int   n;
    int   r;
    exp_t srt[8];
    n = vals.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("fill_ready", 32'(ready), 32'd1);
      chk("fill_valid", 32'(out_valid), 32'd0);
      chk("fill_data", 32'(out_data), 32'd0);
      in_valid = 1'b1;
      in_data  = 8'(vals[i]);
      in_last  = use_last && (i == n - 1);
      desc     = d;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    desc     = ~d;
    if (push) begin
      for (int i = 0; i < n; i++) begin
        r = 0;
        for (int j = 0; j < n; j++)
          if ((d ? vals[j] > vals[i] : vals[j] < vals[i]) || (vals[j] == vals[i] && j < i)) r++;
        srt[r].d  = 8'(vals[i]);
        srt[r].l  = (r == n - 1);
        srt[r].ix = 3'(i);
      end
      for (int i = 0; i < n; i++) exp_q.push_back(srt[i]);
    end
  endtask

  // Drain the scoreboard; stall_pct throttles i_ready, junk drives i_valid during DRAIN.
  task automatic drain(input int stall_pct, input int n, input bit junk);
    int budget;
    budget = 300;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_count", 32'(count), 32'(n));
      chk("drain_ready", 32'(ready), 32'd0);
      if (out_valid) begin
        chk("drain_data", 32'(out_data), 32'(exp_q[0].d));
        chk("drain_last", 32'(out_last), 32'(exp_q[0].l));
`ifdef INSORT_INDEX_EN
        chk("drain_index", 32'(index), 32'(exp_q[0].ix));
`endif
      end
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_ready && out_valid) void'(exp_q.pop_front());
      in_valid = junk && (exp_q.size() > 0);
      in_data  = 8'($urandom_range(255));
      in_last  = 1'b0;
      @(negedge clk);
    end
    chk("drain_budget", 32'(budget > 0), 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_count", 32'(count), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_ready", 32'(ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Ascending full frame with explicit last; zero stall gives consecutive outputs.
    vals = '{5, 3, 7, 1, 8, 2, 6, 4};
    load(1'b0, 1'b1, 1'b1);
    drain(0, 8, 1'b0);

    // Descending, four elements.
    vals = '{10, 40, 20, 30};
    load(1'b1, 1'b1, 1'b1);
    drain(0, 4, 1'b0);

    // Stability with duplicates.
    vals = '{9, 2, 9, 2};
    load(1'b0, 1'b1, 1'b1);
    drain(0, 4, 1'b0);

    // Descending duplicates keep arrival order as well.
    vals = '{5, 7, 5, 7, 5};
    load(1'b1, 1'b1, 1'b1);
    drain(0, 5, 1'b0);

    // Auto-close at DEPTH, junk input during DRAIN, then an independent frame.
    vals = '{200, 17, 99, 17, 0, 255, 64, 128};
    load(1'b1, 1'b0, 1'b1);
    drain(0, 8, 1'b1);
    vals = '{3, 1, 2};
    load(1'b0, 1'b1, 1'b1);
    drain(0, 3, 1'b0);

    // Frame of one.
    vals = '{77};
    load(1'b1, 1'b1, 1'b1);
    drain(0, 1, 1'b0);

    // Backpressure with random frames.
    for (int f = 0; f < 4; f++) begin
      vals.delete();
      for (int i = 0; i < 6; i++) vals.push_back($urandom_range(15));
      load(f[0], 1'b1, 1'b1);
      drain(50, 6, 1'b0);
    end

    // Reset mid-FILL with three elements held.
    vals = '{4, 9, 1};
    load(1'b0, 1'b0, 1'b0);
    chk("midfill_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_fill");
    @(negedge clk);
    rst_n = 1'b1;
    vals = '{6, 2, 8};
    load(1'b1, 1'b1, 1'b1);
    drain(0, 3, 1'b0);

    // Reset mid-DRAIN after one output taken.
    vals = '{11, 5, 33, 22};
    load(1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("middrain_data", 32'(out_data), 32'd11);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_drain");
    @(negedge clk);
    rst_n = 1'b1;
    vals = '{50, 40, 60};
    load(1'b0, 1'b1, 1'b1);
    drain(30, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
